bomb_scheduler: RTL

//  Owns the shared pool of bomb slots for the two-player game. Arbitrates drop requests from

---
 rtl/bomb_pkg.sv | 21 ++
 rtl/bomb_slot.sv | 88 ++++++++
 rtl/bomb_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared constants for the bomb scheduler: slot state encoding, health width,
// winner codes and the saturating health helper.
package bomb_pkg;

    localparam int HP_W = 2;

    localparam logic [1:0] SLOT_IDLE  = 2'd0;
    localparam logic [1:0] SLOT_ARMED = 2'd1;
    localparam logic [1:0] SLOT_BLAST = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                      input logic hit);
        return (hit && (hp != '0)) ? hp - HP_W'(1) : hp;
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: fuse countdown, blast hold, owner and cell; explode pulses on
// the cycle whose tick moves the slot from ARMED to BLAST.
//  state      | meaning
//  SLOT_IDLE  | free, may be granted
//  SLOT_ARMED | fuse counting down on ticks
//  SLOT_BLAST | exploded, blast held until count reaches zero
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int COORD_W     = 4,
    parameter int CNT_W       = 5,
    parameter int FUSE_TICKS  = 20,
    parameter int BLAST_TICKS = 5
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_freeze,
    input  logic                 i_load,
    input  logic                 i_load_owner,
    input  logic [2*COORD_W-1:0] i_load_pos,
    output logic                 o_valid,
    output logic                 o_blast,
    output logic                 o_owner,
    output logic                 o_explode,
    output logic [2*COORD_W-1:0] o_pos
);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_owner;
    logic [2*COORD_W-1:0] r_pos;
    logic                 w_adv;
    logic                 w_last;

    assign w_adv  = i_tick && !i_freeze;
    assign w_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= SLOT_IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
            r_pos   <= '0;
        end else begin
            case (r_state)
                SLOT_IDLE: begin
                    if (i_load) begin
                        r_state <= SLOT_ARMED;
                        r_cnt   <= CNT_W'(FUSE_TICKS);
                        r_owner <= i_load_owner;
                        r_pos   <= i_load_pos;
                    end
                end
                SLOT_ARMED: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_state <= SLOT_BLAST;
                            r_cnt   <= CNT_W'(BLAST_TICKS);
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                SLOT_BLAST: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_state <= SLOT_IDLE;
                            r_cnt   <= '0;
                            r_owner <= 1'b0;
                            r_pos   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: r_state <= SLOT_IDLE;
            endcase
        end
    end

    assign o_valid   = (r_state != SLOT_IDLE);
    assign o_blast   = (r_state == SLOT_BLAST);
    assign o_owner   = r_owner;
    assign o_pos     = r_pos;
    assign o_explode = (r_state == SLOT_ARMED) && w_adv && w_last;

endmodule

// File: rtl/bomb_scheduler.sv
// Shared bomb pool for the two-player game: drop capture, round-robin grant,
// per-owner limits, blast damage, health and game-over tracking.
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int FUSE_TICKS     = 20,
    parameter int BLAST_TICKS    = 5,
    parameter int RANGE          = 2,
    parameter int START_HP       = 3,
    parameter int COORD_W        = 4
)(
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_tick,
    input  logic                           i_drop_a,
    input  logic                           i_drop_b,
    input  logic [2*COORD_W-1:0]           i_pos_a,
    input  logic [2*COORD_W-1:0]           i_pos_b,
    output logic [NUM_SLOTS-1:0]           o_bomb_valid,
    output logic [NUM_SLOTS-1:0]           o_bomb_blast,
    output logic [NUM_SLOTS*2*COORD_W-1:0] o_bomb_pos,
    output logic [1:0]                     o_reject,
    output logic [HP_W-1:0]                o_hp_a,
    output logic [HP_W-1:0]                o_hp_b,
    output logic                           o_game_over,
    output logic [1:0]                     o_winner
);

    localparam int CNT_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int OWN_W   = $clog2(NUM_SLOTS + 1);
    localparam logic [OWN_W-1:0]   ONE_OWN = OWN_W'(1);
    localparam logic [OWN_W-1:0]   MAX_OWN = OWN_W'(MAX_PER_PLAYER);
    localparam logic [COORD_W:0]   RANGE_C = (COORD_W + 1)'(RANGE);

    logic                 r_pend_a, r_pend_b;
    logic [2*COORD_W-1:0] r_lat_a, r_lat_b;
    logic                 r_rr;
    logic [1:0]           r_reject;
    logic [HP_W-1:0]      r_hp_a, r_hp_b;
    logic                 r_game_over;
    logic [1:0]           r_winner;

    logic [NUM_SLOTS-1:0]  w_valid, w_blast, w_owner, w_explode, w_free, w_pick, w_load;
    logic [2*COORD_W-1:0]  w_pos [NUM_SLOTS];
    logic [OWN_W-1:0]      w_cnt_a, w_cnt_b, w_sel_cnt;
    logic                  w_req, w_sel_b, w_collide, w_grant, w_rej;
    logic [2*COORD_W-1:0]  w_sel_pos;
    logic                  w_hit_a, w_hit_b;

    // Blast is a cross along the row and column, reach RANGE cells each way.
    function automatic logic covers(input logic [2*COORD_W-1:0] p,
                                    input logic [2*COORD_W-1:0] b);
        logic [COORD_W-1:0] px, py, bx, by, dx, dy;
        px = p[COORD_W-1:0];
        py = p[2*COORD_W-1:COORD_W];
        bx = b[COORD_W-1:0];
        by = b[2*COORD_W-1:COORD_W];
        dx = (px >= bx) ? px - bx : bx - px;
        dy = (py >= by) ? py - by : by - py;
        return ((py == by) && ({1'b0, dx} <= RANGE_C)) ||
               ((px == bx) && ({1'b0, dy} <= RANGE_C));
    endfunction

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        bomb_slot #(
            .COORD_W    (COORD_W),
            .CNT_W      (CNT_W),
            .FUSE_TICKS (FUSE_TICKS),
            .BLAST_TICKS(BLAST_TICKS)
        ) u_slot (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_tick      (i_tick),
            .i_freeze    (r_game_over),
            .i_load      (w_load[g]),
            .i_load_owner(w_sel_b),
            .i_load_pos  (w_sel_pos),
            .o_valid     (w_valid[g]),
            .o_blast     (w_blast[g]),
            .o_owner     (w_owner[g]),
            .o_explode   (w_explode[g]),
            .o_pos       (w_pos[g])
        );
        assign o_bomb_pos[g*2*COORD_W +: 2*COORD_W] = w_pos[g];
    end

    always_comb begin
        w_cnt_a = '0;
        w_cnt_b = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_valid[i]) begin
                if (w_owner[i]) w_cnt_b = w_cnt_b + ONE_OWN;
                else            w_cnt_a = w_cnt_a + ONE_OWN;
            end
        end
    end

    assign w_req     = r_pend_a || r_pend_b;
    assign w_sel_b   = r_pend_b && (!r_pend_a || r_rr);
    assign w_sel_pos = w_sel_b ? r_lat_b : r_lat_a;
    assign w_sel_cnt = w_sel_b ? w_cnt_b : w_cnt_a;
    assign w_free    = ~w_valid;
    assign w_pick    = w_free & (~w_free + NUM_SLOTS'(1));

    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_valid[i] && (w_pos[i] == w_sel_pos)) w_collide = 1'b1;
        end
    end

    assign w_grant = w_req && !r_game_over && (|w_free) && (w_sel_cnt < MAX_OWN) && !w_collide;
    assign w_rej   = w_req && !w_grant;
    assign w_load  = w_grant ? w_pick : '0;

    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_explode[i]) begin
                if (covers(i_pos_a, w_pos[i])) w_hit_a = 1'b1;
                if (covers(i_pos_b, w_pos[i])) w_hit_b = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_a    <= 1'b0;
            r_pend_b    <= 1'b0;
            r_lat_a     <= '0;
            r_lat_b     <= '0;
            r_rr        <= 1'b0;
            r_reject    <= 2'b00;
            r_hp_a      <= HP_W'(START_HP);
            r_hp_b      <= HP_W'(START_HP);
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_reject <= {w_rej && w_sel_b, w_rej && !w_sel_b};

            if (w_req && !w_sel_b) begin
                r_pend_a <= 1'b0;
            end else if (i_drop_a && !r_pend_a) begin
                r_pend_a <= 1'b1;
                r_lat_a  <= i_pos_a;
            end

            if (w_req && w_sel_b) begin
                r_pend_b <= 1'b0;
            end else if (i_drop_b && !r_pend_b) begin
                r_pend_b <= 1'b1;
                r_lat_b  <= i_pos_b;
            end

            // The pointer only moves when it actually settled a contest.
            if (w_grant && r_pend_a && r_pend_b) r_rr <= !w_sel_b;

            r_hp_a <= hp_after_hit(r_hp_a, w_hit_a);
            r_hp_b <= hp_after_hit(r_hp_b, w_hit_b);

            if (!r_game_over && ((r_hp_a == '0) || (r_hp_b == '0))) begin
                r_game_over <= 1'b1;
                if ((r_hp_a == '0) && (r_hp_b == '0)) r_winner <= WIN_DRAW;
                else if (r_hp_a == '0)                r_winner <= WIN_B;
                else                                  r_winner <= WIN_A;
            end
        end
    end

    assign o_bomb_valid = w_valid;
    assign o_bomb_blast = w_blast;
    assign o_reject     = r_reject;
    assign o_hp_a       = r_hp_a;
    assign o_hp_b       = r_hp_b;
    assign o_game_over  = r_game_over;
    assign o_winner     = r_winner;

endmodule
